ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the dual-port data RAM between the CPU memory stage and a host/DMA loader.
- The RAM has port a (8-bit scalar) and port b (128-bit vector, 12-bit address).
- The CPU has fixed priority, and a starvation counter guarantees DMA forward progress. When DMA takes a forced slot, the block stalls the CPU memory stage.
- Read data from the registered-output RAM is tagged and returned one cycle later to the owner of the access.

Parameters:
- ADDR_W, 16, port-a byte address width.
- VADDR_W, 12, port-b vector address width (low bits of the CPU address).
- DATA_W, 8, scalar data width.
- VDATA_W, 128, vector data width.
- STARVE_LIMIT, 4, consecutive denied DMA cycles before a forced DMA slot. Legal range 1..255.

Ports:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- cpu_req  in  1  memory-stage access request.
- cpu_we_a  in  1  scalar write.
- cpu_we_b  in  1  vector write.
- cpu_addr  in  ADDR_W  address; port b uses cpu_addr[VADDR_W-1:0].
- cpu_wdata_a  in  DATA_W  scalar write data.
- cpu_wdata_b  in  VDATA_W  vector write data.
- cpu_stall  out  1  freeze the ExecuteMemory register and hold the request.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata_a  out  DATA_W  scalar read data.
- cpu_rdata_b  out  VDATA_W  vector read data.
- dma_req  in  1  loader request (port a only).
- dma_we  in  1  loader write.
- dma_addr  in  ADDR_W  loader address.
- dma_wdata  in  DATA_W  loader write data.
- dma_gnt  out  1  loader access accepted this cycle.
- dma_rvalid  out  1  loader read data valid.
- dma_rdata  out  DATA_W  loader read data.
- ram_address_a  out  ADDR_W  RAM port-a address.
- ram_address_b  out  VADDR_W  RAM port-b address.
- ram_data_a  out  DATA_W  RAM port-a write data.
- ram_data_b  out  VDATA_W  RAM port-b write data.
- ram_wren_a  out  1  RAM port-a write enable.
- ram_wren_b  out  1  RAM port-b write enable.
- ram_q_a  in  DATA_W  RAM port-a read data, registered, 1-cycle latency.
- ram_q_b  in  VDATA_W  RAM port-b read data, registered, 1-cycle latency.

Behaviour:
- Clock port is clk; reset is asynchronous, active-high, named reset.
- State machine states:
  - NORMAL: grant is combinational from the inputs. cpu_req=1 gives the grant to the CPU. Else dma_req=1 gives dma_gnt=1. cpu_stall=0.
  - FORCE: dma_gnt=dma_req. cpu_stall=cpu_req & dma_req. If dma_req=0, no access is made, cpu_stall=0, and the next state is NORMAL.
  - FORCE lasts exactly one cycle, then returns to NORMAL.
- starve_cnt (8 bit):
  - +1 on each cycle with dma_req & ~dma_gnt.
  - Cleared on dma_gnt or on dma_req=0.
  - When the next value reaches STARVE_LIMIT: next state is FORCE and the counter clears.
- RAM muxing:
  - CPU owner: CPU fields drive the RAM; ram_wren_a=cpu_we_a, ram_wren_b=cpu_we_b.
  - DMA owner: dma fields drive port a; ram_wren_b=0; ram_address_b and ram_data_b carry CPU values.
  - No owner, or reset=1: both wren=0; address and data carry CPU values.
- Read return:
  - A granted access with all its write enables low sets a 2-bit tag register {cpu,dma} at the clock edge.
  - The next cycle, cpu_rvalid or dma_rvalid = the tag bit.
  - cpu_rdata_a=ram_q_a and cpu_rdata_b=ram_q_b when cpu_rvalid, else 0.
  - dma_rdata=ram_q_a when dma_rvalid, else 0.
  - The tag clears when no read is granted.
- Writes: zero-latency commit at the granted edge; no rvalid pulse.
- Mixed write a / read b from the CPU counts as a read; cpu_rvalid follows.
- Reset, including mid-operation:
  - State=NORMAL, starve_cnt=0, tags=0, so rvalid=0.
  - Outputs during reset: cpu_stall=0, dma_gnt=0, wren=0.
  - Any pending read data is discarded.
- CPU contract: cpu_req and its fields stay stable while cpu_stall=1. The stalled access is granted the following cycle.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, adds three outputs, all cleared by reset and saturating at all-ones:
  - perf_cpu_grants out 32: counts CPU grants.
  - perf_dma_grants out 32: counts DMA grants.
  - perf_stall_cycles out 32: counts cycles with cpu_stall=1.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset with cpu_req=1, cpu_we_a=1 -> ram_wren_a=0, cpu_stall=0, dma_gnt=0, both rvalid=0.
- CPU scalar write addr 0x0010 data 0x5A, then CPU read 0x0010 -> ram_wren_a=1 on the write cycle; one cycle after the read grant, cpu_rvalid=1 and cpu_rdata_a=0x5A.
- cpu_req=1 continuously, dma_req=1 from cycle 0, STARVE_LIMIT=4 -> dma_gnt=0 on cycles 0-3 and 1 on cycle 4; cpu_stall=1 on cycle 4 only; CPU granted cycle 5; pattern repeats every 5 cycles.
- DMA read addr 0x0020 (holds 0xA7) with cpu_req=0 -> immediate dma_gnt=1; next cycle dma_rvalid=1, dma_rdata=0xA7, cpu_rvalid=0.
- CPU vector write cpu_we_b=1 addr 0x0003, data 128'h1 -> ram_wren_b=1, ram_address_b=12'h003; a following DMA-owned cycle keeps ram_wren_b=0.
- FORCE entered, dma_req dropped that cycle, and reset asserted after a CPU read grant -> no grant and cpu_stall=0 in FORCE; state returns to NORMAL; the pending cpu_rvalid is suppressed by reset.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Arbitrates the dual-port data RAM between the CPU memory stage and a host/DMA loader.
// Define ARB_PERF_CNT_EN to add saturating grant/stall performance counters.
module ram_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int VADDR_W      = 12,
  parameter int DATA_W       = 8,
  parameter int VDATA_W      = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_we_a,
  input  logic               cpu_we_b,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata_a,
  input  logic [VDATA_W-1:0] cpu_wdata_b,
  output logic               cpu_stall,
  output logic               cpu_rvalid,
  output logic [DATA_W-1:0]  cpu_rdata_a,
  output logic [VDATA_W-1:0] cpu_rdata_b,
  input  logic               dma_req,
  input  logic               dma_we,
  input  logic [ADDR_W-1:0]  dma_addr,
  input  logic [DATA_W-1:0]  dma_wdata,
  output logic               dma_gnt,
  output logic               dma_rvalid,
  output logic [DATA_W-1:0]  dma_rdata,
  output logic [ADDR_W-1:0]  ram_address_a,
  output logic [VADDR_W-1:0] ram_address_b,
  output logic [DATA_W-1:0]  ram_data_a,
  output logic [VDATA_W-1:0] ram_data_b,
  output logic               ram_wren_a,
  output logic               ram_wren_b,
  input  logic [DATA_W-1:0]  ram_q_a,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]        perf_cpu_grants,
  output logic [31:0]        perf_dma_grants,
  output logic [31:0]        perf_stall_cycles,
`endif
  input  logic [VDATA_W-1:0] ram_q_b
);

  typedef enum logic {NORMAL, FORCE} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t     state;
  logic [7:0] starve_cnt;
  logic [7:0] starve_inc;
  logic       starve_hit;
  logic       dma_denied;
  logic       cpu_gnt;
  logic       cpu_vld_p1;
  logic       dma_vld_p1;

  // Grant decode: CPU wins in NORMAL; the FORCE slot belongs to the DMA alone.
  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    cpu_stall = 1'b0;
    if (!reset) begin
      if (state == FORCE) begin
        dma_gnt   = dma_req;
        cpu_stall = cpu_req & dma_req;
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req & ~cpu_req;
      end
    end
  end

  assign dma_denied = dma_req & ~dma_gnt;
  assign starve_inc = starve_cnt + 8'd1;
  assign starve_hit = (state == NORMAL) && dma_denied && (starve_inc == LIMIT);

  // RAM port steering; port b always carries CPU fields, only its enable is gated.
  always_comb begin
    ram_address_a = cpu_addr;
    ram_data_a    = cpu_wdata_a;
    ram_address_b = cpu_addr[VADDR_W-1:0];
    ram_data_b    = cpu_wdata_b;
    ram_wren_a    = 1'b0;
    ram_wren_b    = 1'b0;
    if (cpu_gnt) begin
      ram_wren_a = cpu_we_a;
      ram_wren_b = cpu_we_b;
    end else if (dma_gnt) begin
      ram_address_a = dma_addr;
      ram_data_a    = dma_wdata;
      ram_wren_a    = dma_we;
    end
  end

  // Stage p0 -> p1: arbitration state and read-return tags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= NORMAL;
      starve_cnt <= 8'd0;
      cpu_vld_p1 <= 1'b0;
      dma_vld_p1 <= 1'b0;
    end else begin
      // A CPU access that leaves port b reading returns data, even alongside a scalar write.
      cpu_vld_p1 <= cpu_gnt & ~cpu_we_b;
      dma_vld_p1 <= dma_gnt & ~dma_we;
      if (starve_hit) begin
        state      <= FORCE;
        starve_cnt <= 8'd0;
      end else begin
        state      <= NORMAL;
        starve_cnt <= dma_denied ? starve_inc : 8'd0;
      end
    end
  end

  // Stage p1: registered RAM output returned to the tagged owner
  assign cpu_rvalid  = cpu_vld_p1;
  assign dma_rvalid  = dma_vld_p1;
  assign cpu_rdata_a = cpu_vld_p1 ? ram_q_a : '0;
  assign cpu_rdata_b = cpu_vld_p1 ? ram_q_b : '0;
  assign dma_rdata   = dma_vld_p1 ? ram_q_a : '0;

`ifdef ARB_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cpu_grants   <= 32'd0;
      perf_dma_grants   <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      if (cpu_gnt)   perf_cpu_grants   <= sat_inc(perf_cpu_grants);
      if (dma_gnt)   perf_dma_grants   <= sat_inc(perf_dma_grants);
      if (cpu_stall) perf_stall_cycles <= sat_inc(perf_stall_cycles);
    end
  end
`endif

endmodule
